// File: rtl/divider_if.sv
// Request/response bundle between the execute-stage control and the iterative divider.
// The master drives the request and kill lines, and the slave returns ready, done and result.
interface divider_if;
  logic        div_valid;
  logic [1:0]  div_op;
  logic [31:0] div_rs1;
  logic [31:0] div_rs2;
  logic        div_kill;
  logic        div_ready;
  logic        div_done;
  logic [31:0] div_result;

  modport master (
    output div_valid, div_op, div_rs1, div_rs2, div_kill,
    input  div_ready, div_done, div_result
  );

  modport slave (
    input  div_valid, div_op, div_rs1, div_rs2, div_kill,
    output div_ready, div_done, div_result
  );
endinterface

// File: rtl/divider.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divider, one quotient bit per cycle.
// Division by zero and signed overflow resolve at the accept edge without iterating.
module divider (
  input  logic     clock,
  input  logic     reset,
  divider_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 5;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            rem_op_q, rem_op_d;
  logic            neg_q, neg_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;

  logic            accept_c;
  logic            is_signed_c;
  logic            sign1_c, sign2_c;
  logic            div_zero_c, overflow_c, special_c;
  logic [XLEN-1:0] mag1_c, mag2_c, special_res_c;

  // Request decode: operand magnitudes and the two early-out cases.
  always_comb begin
    accept_c    = (state_q == S_IDLE) && bus.div_valid && !bus.div_kill;
    is_signed_c = !bus.div_op[0];
    sign1_c     = is_signed_c && bus.div_rs1[XLEN-1];
    sign2_c     = is_signed_c && bus.div_rs2[XLEN-1];
    mag1_c      = sign1_c ? (~bus.div_rs1 + XLEN'(1)) : bus.div_rs1;
    mag2_c      = sign2_c ? (~bus.div_rs2 + XLEN'(1)) : bus.div_rs2;
    div_zero_c  = (bus.div_rs2 == '0);
    overflow_c  = is_signed_c && (bus.div_rs1 == INT_MIN) && (bus.div_rs2 == '1);
    special_c   = div_zero_c || overflow_c;
    if (div_zero_c) begin
      special_res_c = bus.div_op[1] ? bus.div_rs1 : '1;
    end else begin
      special_res_c = bus.div_op[1] ? '0 : INT_MIN;
    end
  end

  logic [XLEN:0]   shifted_c;
  logic [XLEN-1:0] trial_c, rem_step_c, quo_step_c, quo_fin_c, rem_fin_c;
  logic            qbit_c;

  // One restoring step; the remainder stays below the divisor, so 32 bits hold it between steps.
  always_comb begin
    shifted_c  = {rem_q, dvd_q[XLEN-1]};
    qbit_c     = (shifted_c >= {1'b0, dsr_q});
    trial_c    = XLEN'(shifted_c - {1'b0, dsr_q});
    rem_step_c = qbit_c ? trial_c : shifted_c[XLEN-1:0];
    quo_step_c = {dvd_q[XLEN-2:0], qbit_c};
    quo_fin_c  = neg_q ? (~quo_step_c + XLEN'(1)) : quo_step_c;
    rem_fin_c  = neg_q ? (~rem_step_c + XLEN'(1)) : rem_step_c;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Kill overrides every transition, including a simultaneous request.
  always_comb begin
    state_d = state_q;
    if (bus.div_kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.div_valid) state_d = special_c ? S_DONE : S_BUSY;
        S_BUSY:  if (cnt_q == '0)   state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    result_d = result_q;
    rem_op_d = rem_op_q;
    neg_d    = neg_q;
    ready_d  = (state_d == S_IDLE);
    done_d   = (state_d == S_DONE);

    if (accept_c) begin
      rem_op_d = bus.div_op[1];
      neg_d    = bus.div_op[1] ? sign1_c : (sign1_c ^ sign2_c);
      if (special_c) begin
        result_d = special_res_c;
      end else begin
        cnt_d = CNTW'(XLEN - 1);
        rem_d = '0;
        dvd_d = mag1_c;
        dsr_d = mag2_c;
      end
    end else if (state_q == S_BUSY && !bus.div_kill) begin
      cnt_d = cnt_q - CNTW'(1);
      rem_d = rem_step_c;
      dvd_d = quo_step_c;
      if (cnt_q == '0) begin
        result_d = rem_op_q ? rem_fin_c : quo_fin_c;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      result_q <= '0;
      rem_op_q <= 1'b0;
      neg_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      result_q <= result_d;
      rem_op_q <= rem_op_d;
      neg_q    <= neg_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign bus.div_ready  = ready_q;
  assign bus.div_done   = done_q;
  assign bus.div_result = result_q;
endmodule
